// File: rtl/ula_seq.sv
// Registered ALU: single-cycle arithmetic/logic/shift ops plus iterative
// multiply, divide and remainder behind a Start/Busy/Done handshake.
//
// Handshake: Start, CodeULA, OpA and OpB are sampled on a rising edge only
// while Busy is 0. Busy is high while an iterative op runs. Done pulses for one
// cycle when Res/FlagReg hold a new result. Done and Busy are never both high.
module ula_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [3:0]       CodeULA,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [WIDTH-1:0] Res,
  output logic [2:0]       FlagReg,
  output logic             Busy,
  output logic             Done,
  output logic [0:0]       DbgState
);
  localparam int SW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_BEZ = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_REM = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011;
  localparam logic [3:0] OP_SRA = 4'b1100;

  localparam logic [WIDTH-1:0] ONE      = 1;
  localparam logic [SW:0]      CNT_ONE  = 1;
  localparam logic [SW:0]      CNT_INIT = (SW+1)'(WIDTH);

  logic [0:0]       state;
  logic [SW:0]      cnt;
  logic [3:0]       code;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;

  logic [WIDTH-1:0] scRes;
  logic [2:0]       scFlags;
  logic             scV;
  logic             scBez;
  logic             scNone;
  logic             isIter;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] negB;

  always_comb begin
    scRes  = '0;
    scV    = 1'b0;
    scBez  = 1'b0;
    scNone = 1'b0;
    isIter = 1'b0;
    sh     = OpB[SW-1:0];
    negB   = ~OpB + ONE;
    case (CodeULA)
      OP_ADD: begin
        scRes = OpA + OpB;
        scV   = (OpA[MSB] == OpB[MSB]) && (scRes[MSB] != OpA[MSB]);
      end
      OP_SUB: begin
        scRes = OpA + negB;
        scV   = (OpA[MSB] == negB[MSB]) && (scRes[MSB] != OpA[MSB]);
      end
      OP_SLT: scRes = (OpA > OpB) ? ONE : '0;
      OP_AND: scRes = OpA & OpB;
      OP_OR:  scRes = OpA | OpB;
      OP_XOR: scRes = OpA ^ OpB;
      OP_BEZ: begin
        scRes = OpB;
        scBez = 1'b1;
      end
      OP_SLL: scRes = OpA << sh;
      OP_SRL: scRes = OpA >> sh;
      OP_SRA: scRes = $unsigned($signed(OpA) >>> sh);
      OP_MUL: isIter = 1'b1;
      // A zero divisor is resolved here so the op finishes in one cycle.
      OP_DIV: begin
        if (OpB == '0) begin
          scRes = '1;
          scV   = 1'b1;
        end else begin
          isIter = 1'b1;
        end
      end
      OP_REM: begin
        if (OpB == '0) begin
          scRes = OpA;
          scV   = 1'b1;
        end else begin
          isIter = 1'b1;
        end
      end
      default: scNone = 1'b1;
    endcase
    if (scNone)     scFlags = 3'b000;
    else if (scBez) scFlags = {(OpA == '0), 2'b00};
    else            scFlags = {(scRes == '0), scRes[MSB], scV};
  end

  // One radix-2 step. MUL keeps the product high half in acc and shifts the
  // low half into opB; DIV/REM keeps the partial remainder in acc, divisor in
  // opA, and shifts dividend bits out of / quotient bits into opB.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH:0]   divDiff;
  logic [WIDTH-1:0] nAcc;
  logic [WIDTH-1:0] nQ;
  logic [WIDTH-1:0] finRes;
  logic             finV;

  always_comb begin
    mulSum   = {1'b0, acc} + (opB[0] ? {1'b0, opA} : '0);
    divTrial = {acc, opB[MSB]};
    divDiff  = divTrial - {1'b0, opA};
    if (code == OP_MUL) begin
      nAcc = mulSum[WIDTH:1];
      nQ   = {mulSum[0], opB[MSB:1]};
    end else if (!divDiff[WIDTH]) begin
      nAcc = divDiff[WIDTH-1:0];
      nQ   = {opB[MSB-1:0], 1'b1};
    end else begin
      nAcc = divTrial[WIDTH-1:0];
      nQ   = {opB[MSB-1:0], 1'b0};
    end
    finRes = (code == OP_REM) ? nAcc : nQ;
    finV   = (code == OP_MUL) ? (nAcc != '0) : 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      code    <= '0;
      acc     <= '0;
      opA     <= '0;
      opB     <= '0;
      Res     <= '0;
      FlagReg <= 3'b000;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (isIter) begin
              state <= CALC;
              code  <= CodeULA;
              acc   <= '0;
              cnt   <= CNT_INIT;
              if (CodeULA == OP_MUL) begin
                opA <= OpA;
                opB <= OpB;
              end else begin
                opA <= OpB;
                opB <= OpA;
              end
            end else begin
              Res     <= scRes;
              FlagReg <= scFlags;
              Done    <= 1'b1;
            end
          end
        end
        CALC: begin
          acc <= nAcc;
          opB <= nQ;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            Res     <= finRes;
            FlagReg <= {(finRes == '0), finRes[MSB], finV};
            Done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy     = (state == CALC);
  assign DbgState = state;

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, registered ALU that succeeds the combinational 16-bit ALU in the microprocessor datapath. It keeps the existing 4-bit operation codes and [Z N V] flag register, and generalises the data width. It adds single-cycle shifts and iterative multiply, divide and remainder behind a start/busy/done handshake. The control unit issues an operation, stalls while `Busy` is high, and captures `Res`/`FlagReg` on `Done`.

## Interface
- `WIDTH`, 16: operand/result width; power of two, ≥ 4. Shift-amount width `SW = $clog2(WIDTH)`.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `Start`  in  1: request; sampled only when `Busy` = 0.
- `CodeULA`  in  4: operation code, sampled with `Start`.
- `OpA`, `OpB`  in  WIDTH: operands, sampled with `Start`; need not be held afterwards.
- `Res`  out  WIDTH: registered result; holds until the next completion.
- `FlagReg`  out  3: registered [2]=Z, [1]=N, [0]=V.
- `Busy`  out  1: iterative operation in progress.
- `Done`  out  1: one-cycle pulse; `Res`/`FlagReg` are valid and updated.

## Operation
- Opcodes, single-cycle:
  - 0000 ADD: A+B mod 2^WIDTH.
  - 0001 SUB: A−B.
  - 0010 SLT: 1 if A>B unsigned, else 0.
  - 0011 AND, 0100 OR, 0101 XOR: bitwise.
  - 0110 BEZ: Res=B; Z=(A==0); N=V=0.
  - 1010 SLL, 1011 SRL, 1100 SRA: A shifted by B[SW-1:0].
- Opcodes, iterative:
  - 0111 MUL: low WIDTH bits of unsigned A×B.
  - 1000 DIV: unsigned quotient.
  - 1001 REM: unsigned remainder.
- Other codes: Res=0, FlagReg=000, `Done` still pulses.
- Flags, except BEZ: Z=(Res==0); N=Res[WIDTH-1]; V as follows.
  - ADD: signed overflow, (A,B same sign, Res sign differs).
  - SUB: signed overflow of A+(~B+1).
  - MUL: V=1 if the upper WIDTH bits of the full product are nonzero.
  - DIV/REM with B=0: Res = all ones (DIV) or A (REM); V=1.
  - All other ops: V=0. No X is ever driven on the flags.
- FSM states:
  - IDLE: `Start` with a single-cycle op loads Res/FlagReg, stays in IDLE. `Start` with MUL/DIV/REM latches A, B and opcode, clears the accumulator, loads counter=WIDTH, and goes to CALC.
  - CALC: one radix-2 step per cycle. MUL: shift-add over a 2×WIDTH product. DIV/REM: restoring shift-subtract. Counter decrements each step. The step that takes the counter to 0 loads Res/FlagReg and goes to IDLE.
  - Divide-by-zero is detected at the `Start` edge: result is loaded immediately (single-cycle latency) and CALC is not entered.
- `Start` while `Busy`=1: ignored. No latch, no effect on the running operation, no queueing.

## Timing
- Reset values (immediate on `RST` assertion, independent of `CLK`): Res=0, FlagReg=000, Busy=0, Done=0, state IDLE, counter=0, internal operand/accumulator registers 0.
- Edge E0 is the rising edge with `Start`=1 and `Busy`=0.
- Single-cycle ops: Res/FlagReg updated at E0. `Done`=1 during the cycle after E0. Back-to-back `Start` every cycle gives one result per cycle, with `Done` high continuously.
- Iterative ops:
  - `Busy`=1 from E0 through edge E0+WIDTH.
  - At E0+WIDTH: Res/FlagReg loaded, `Busy`→0, `Done`→1 for exactly one cycle.
  - Latency is WIDTH cycles; WIDTH=16 gives 16.
- A new `Start` is accepted on the same edge at which `Busy` falls only if `Busy` was 0 before that edge. Hence the earliest new issue after an iterative op is E0+WIDTH+1.
- `RST` asserted mid-CALC aborts the operation: no `Done`, outputs return to reset values, and the partial result is discarded.
- `Done` is never high in the same cycle as `Busy`.

## Test plan
- Reset, then ADD 0x7FFF+0x0001 → Res=0x8000, FlagReg=011 (N,V), `Done` one cycle after E0. Then SUB 0x0005−0x0005 → Res=0, FlagReg=100.
- MUL 0x0100×0x0100 → after 16 cycles Res=0x0000, FlagReg=101 (Z,V). MUL 0x00FF×0x0003 → Res=0x02FD, FlagReg=000. `Busy` high exactly 16 cycles.
- DIV 100/7 → Res=14, FlagReg=000. REM 100/7 → Res=2. DIV 0x1234/0 → Res=0xFFFF, V=1, `Done` after 1 cycle. REM 0x1234/0 → Res=0x1234, V=1.
- SRA 0x8000 by 15 → 0xFFFF, N=1. SRL 0x8000 by 15 → 0x0001. BEZ A=0, B=0x00AA → Res=0x00AA, FlagReg=100. Opcode 1111 → Res=0, FlagReg=000, `Done` pulses.
- During a running MUL, pulse `Start` with ADD 1+1 → ignored; the MUL result is unchanged and exactly one `Done` occurs.
- Assert `RST` 8 cycles into a DIV → all outputs 0 immediately, no `Done`. A subsequent ADD 2+3 → Res=5 with 1-cycle latency.
